// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix operand loader.
package mm_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  localparam logic [2:0] RNE = 3'b000;

  // Number of accepted elements that make up one complete frame.
  function automatic int elem_count(input int rows, input int vec, input int cols);
    return rows * vec + vec * cols;
  endfunction

  // Index width for a dimension; a dimension of 1 still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_index_counter.sv
// Row-major 2-D index counter with runtime limits so one instance can walk
// both operand matrices in turn.
module mm_index_counter #(
  parameter int ROW_W = 2,
  parameter int COL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [ROW_W-1:0] row_last,
  input  logic [COL_W-1:0] col_last,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  assign last = (row == row_last) && (col == col_last);

  // Clear wins over enable so a frame boundary always restarts at (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == col_last) begin
        col <= '0;
        row <= (row == row_last) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Assembles a serial element stream into matrix A then matrix B and holds the
// complete frame for the downstream multiplier until it is taken.
module matrix_operand_loader
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int MATRIX_A_ROWS = 4,
  parameter int VECTOR_SIZE   = 4,
  parameter int MATRIX_B_COLS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [2:0]            in_round_mode,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] matrix_a [MATRIX_A_ROWS][VECTOR_SIZE],
  output logic [DATA_WIDTH-1:0] matrix_b [VECTOR_SIZE][MATRIX_B_COLS],
  output logic [2:0]            round_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err
);

  localparam int A_RW  = idx_width(MATRIX_A_ROWS);
  localparam int A_CW  = idx_width(VECTOR_SIZE);
  localparam int B_RW  = idx_width(VECTOR_SIZE);
  localparam int B_CW  = idx_width(MATRIX_B_COLS);
  localparam int ROW_W = (A_RW > B_RW) ? A_RW : B_RW;
  localparam int COL_W = (A_CW > B_CW) ? A_CW : B_CW;

  state_t           state_q, state_d;
  logic             accept;
  logic             cnt_en, cnt_clr, cnt_last;
  logic             err_d;
  logic             wr_a, wr_b;
  logic [ROW_W-1:0] cnt_row, row_last;
  logic [COL_W-1:0] cnt_col, col_last;

  assign in_ready  = rst_n && (state_q != FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == FULL);

  assign row_last = (state_q == LOAD_B) ? ROW_W'(VECTOR_SIZE - 1)   : ROW_W'(MATRIX_A_ROWS - 1);
  assign col_last = (state_q == LOAD_B) ? COL_W'(MATRIX_B_COLS - 1) : COL_W'(VECTOR_SIZE - 1);

  mm_index_counter #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_index (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .row_last (row_last),
    .col_last (col_last),
    .row      (cnt_row),
    .col      (cnt_col),
    .last     (cnt_last)
  );

  // Only the final B element may carry in_last; anywhere else it aborts the frame.
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    err_d   = 1'b0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (accept) begin
          if (in_last) begin
            cnt_clr = 1'b1;
            err_d   = 1'b1;
          end else if (cnt_last) begin
            wr_a    = 1'b1;
            cnt_clr = 1'b1;
            state_d = LOAD_B;
          end else begin
            wr_a   = 1'b1;
            cnt_en = 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          if (cnt_last) begin
            wr_b    = 1'b1;
            cnt_clr = 1'b1;
            err_d   = !in_last;
            state_d = FULL;
          end else if (in_last) begin
            cnt_clr = 1'b1;
            err_d   = 1'b1;
            state_d = LOAD_A;
          end else begin
            wr_b   = 1'b1;
            cnt_en = 1'b1;
          end
        end
      end
      FULL: begin
        if (out_ready) state_d = LOAD_A;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LOAD_A;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_err <= err_d;
    end
  end

  // Round mode travels with the frame and is captured on its first A element.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      round_mode <= RNE;
      for (int r = 0; r < MATRIX_A_ROWS; r++)
        for (int c = 0; c < VECTOR_SIZE; c++)
          matrix_a[r][c] <= '0;
      for (int r = 0; r < VECTOR_SIZE; r++)
        for (int c = 0; c < MATRIX_B_COLS; c++)
          matrix_b[r][c] <= '0;
    end else begin
      if (wr_a) begin
        matrix_a[cnt_row[A_RW-1:0]][cnt_col[A_CW-1:0]] <= in_data;
        if (cnt_row == '0 && cnt_col == '0)
          round_mode <= in_round_mode;
      end
      if (wr_b)
        matrix_b[cnt_row[B_RW-1:0]][cnt_col[B_CW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: framing, hold/release, gaps,
// in_last errors and mid-frame reset with hand-computed element values.
module tb_matrix_operand_loader;

  localparam int DW = 32;
  localparam int R  = 4;
  localparam int K  = 4;
  localparam int C  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic [2:0]    in_round_mode;
  logic          in_ready;
  logic [DW-1:0] matrix_a [R][K];
  logic [DW-1:0] matrix_b [K][C];
  logic [2:0]    round_mode;
  logic          out_valid;
  logic          out_ready;
  logic          frame_err;

  int nChecks = 0;
  int nErrors = 0;
  int cycle   = 0;
  int c0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  matrix_operand_loader #(
    .DATA_WIDTH    (DW),
    .MATRIX_A_ROWS (R),
    .VECTOR_SIZE   (K),
    .MATRIX_B_COLS (C)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_round_mode (in_round_mode),
    .in_ready      (in_ready),
    .matrix_a      (matrix_a),
    .matrix_b      (matrix_b),
    .round_mode    (round_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .frame_err     (frame_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic sendElem(input logic [31:0] d, input logic last, input logic [2:0] rm);
    waitReady();
    in_valid      = 1'b1;
    in_data       = d;
    in_last       = last;
    in_round_mode = rm;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends base..base+31; round mode other than on element 0 is junk (3'b111).
  task automatic applyStimulus(input int base, input logic [2:0] rm, input logic markLast, input bit gaps);
    for (int i = 0; i < R*K + K*C; i++) begin
      sendElem(32'(base + i), markLast && (i == R*K + K*C - 1), (i == 0) ? rm : 3'b111);
      if (gaps && i < R*K + K*C - 1) tick();
    end
  endtask

  task automatic checkFrame(input string pfx, input int base, input logic [2:0] rm);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < K; c++)
        checkOutput($sformatf("%s_a[%0d][%0d]", pfx, r, c), matrix_a[r][c], 32'(base + r*K + c));
    for (int r = 0; r < K; r++)
      for (int c = 0; c < C; c++)
        checkOutput($sformatf("%s_b[%0d][%0d]", pfx, r, c), matrix_b[r][c], 32'(base + R*K + r*C + c));
    checkOutput({pfx, "_round_mode"}, 32'(round_mode), 32'(rm));
  endtask

  initial begin
    rst_n         = 1'b0;
    in_data       = '0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_round_mode = 3'b000;
    out_ready     = 1'b0;
    tick(); tick(); tick();
    checkOutput("rst_in_ready",   32'(in_ready),   32'd0);
    checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
    checkOutput("rst_frame_err",  32'(frame_err),  32'd0);
    checkOutput("rst_round_mode", 32'(round_mode), 32'd0);
    checkOutput("rst_a23",        matrix_a[2][3],  32'd0);
    checkOutput("rst_b11",        matrix_b[1][1],  32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] basic frame 1..32 with immediate release");
    out_ready = 1'b1;
    applyStimulus(1, 3'b011, 1'b1, 1'b0);
    checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_in_ready",  32'(in_ready),  32'd0);
    checkOutput("t1_frame_err", 32'(frame_err), 32'd0);
    checkOutput("t1_a12",       matrix_a[1][2], 32'd7);
    checkOutput("t1_b30",       matrix_b[3][0], 32'd29);
    checkFrame("t1", 1, 3'b011);
    tick();
    checkOutput("t1_out_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("t1_in_ready_back",  32'(in_ready),  32'd1);

    $display("[TB] hold for 10 cycles, then second frame 101..132");
    out_ready = 1'b0;
    applyStimulus(1, 3'b001, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd999;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("t2_hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("t2_hold_in_ready",  32'(in_ready),  32'd0);
      checkOutput("t2_hold_a00",       matrix_a[0][0], 32'd1);
      checkOutput("t2_hold_b33",       matrix_b[3][3], 32'd32);
      checkOutput("t2_hold_rm",        32'(round_mode), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("t2_release_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(101, 3'b100, 1'b1, 1'b0);
    checkOutput("t2_second_out_valid", 32'(out_valid), 32'd1);
    checkFrame("t2", 101, 3'b100);
    tick();

    $display("[TB] alternating in_valid gaps");
    c0 = cycle;
    applyStimulus(1, 3'b011, 1'b1, 1'b1);
    checkOutput("t3_gap_cycles", 32'(cycle - c0), 32'd63);
    checkOutput("t3_out_valid",  32'(out_valid),  32'd1);
    checkFrame("t3", 1, 3'b011);
    tick();

    $display("[TB] early in_last on element 5");
    for (int i = 0; i < 5; i++)
      sendElem(32'(201 + i), i == 4, (i == 0) ? 3'b101 : 3'b111);
    checkOutput("t4_err_pulse",     32'(frame_err), 32'd1);
    checkOutput("t4_out_valid",     32'(out_valid), 32'd0);
    tick();
    checkOutput("t4_err_clear",     32'(frame_err), 32'd0);
    checkOutput("t4_out_valid_low", 32'(out_valid), 32'd0);
    checkOutput("t4_in_ready",      32'(in_ready),  32'd1);
    applyStimulus(301, 3'b110, 1'b1, 1'b0);
    checkOutput("t4_clean_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t4_clean_frame_err", 32'(frame_err), 32'd0);
    checkFrame("t4", 301, 3'b110);
    tick();

    $display("[TB] missing in_last on final element");
    applyStimulus(401, 3'b010, 1'b0, 1'b0);
    checkOutput("t5_out_valid", 32'(out_valid), 32'd1);
    checkOutput("t5_frame_err", 32'(frame_err), 32'd1);
    checkFrame("t5", 401, 3'b010);
    tick();
    checkOutput("t5_err_clear",   32'(frame_err), 32'd0);
    checkOutput("t5_out_valid_0", 32'(out_valid), 32'd0);

    $display("[TB] reset after 20 elements");
    for (int i = 0; i < 20; i++)
      sendElem(32'(501 + i), 1'b0, (i == 0) ? 3'b101 : 3'b111);
    rst_n = 1'b0;
    tick();
    checkOutput("t6_rst_in_ready",  32'(in_ready),   32'd0);
    checkOutput("t6_rst_out_valid", 32'(out_valid),  32'd0);
    checkOutput("t6_rst_rm",        32'(round_mode), 32'd0);
    checkOutput("t6_rst_a00",       matrix_a[0][0],  32'd0);
    checkOutput("t6_rst_b03",       matrix_b[0][3],  32'd0);
    rst_n = 1'b1;
    applyStimulus(601, 3'b010, 1'b1, 1'b0);
    checkOutput("t6_out_valid", 32'(out_valid), 32'd1);
    checkFrame("t6", 601, 3'b010);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nErrors);
    $finish;
  end

endmodule
